// File: rtl/crc_pkg.sv
// Shared types and default parameters for the serial CRC transmitter.
// Holds the frame FSM states and the CRC-8 (x^8+x^2+x+1) defaults.
package crc_pkg;

  localparam int              DATA_LEN_DEF = 8;
  localparam int              CRC_W_DEF    = 8;
  localparam logic [7:0]      POLY_DEF     = 8'h07;
  localparam logic [7:0]      INIT_DEF     = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } state_t;

endpackage

// File: rtl/crc_step.sv
// Single-bit MSB-first LFSR update: no reflection, no final XOR.
// Purely combinational; the caller decides when the result is registered.
module crc_step #(
  parameter int               CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = 8'h07
) (
  input  logic [CRC_W-1:0] crc,
  input  logic             d,
  output logic [CRC_W-1:0] crc_next
);

  logic fb;

  assign fb       = crc[CRC_W-1] ^ d;
  assign crc_next = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc_transmitter.sv
// Serial frame transmitter: passes DATA_LEN payload bits through with one cycle
// of latency, then shifts out the CRC_W-bit CRC, then a closing zero bit.
module crc_transmitter
  import crc_pkg::*;
#(
  parameter int               DATA_LEN = DATA_LEN_DEF,
  parameter int               CRC_W    = CRC_W_DEF,
  parameter logic [CRC_W-1:0] POLY     = POLY_DEF,
  parameter logic [CRC_W-1:0] INIT     = INIT_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable,
  input  logic crc_in,
  output logic crc_out
);

  localparam int CNT_MAX = (DATA_LEN > CRC_W) ? DATA_LEN : CRC_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_LEN - 1);
  localparam logic [CNT_W-1:0] CRC_END   = CNT_W'(CRC_W);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CRC_W-1:0] crc_q, crc_d, crc_stepped;
  logic             out_q, out_d;

  crc_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_crc_step (
    .crc      (crc_q),
    .d        (crc_in),
    .crc_next (crc_stepped)
  );

  always_comb begin
    // NOTE: every variable gets a hold-value default first so no path through the case infers a latch.
    state_d = state_q;
    count_d = count_q;
    crc_d   = crc_q;
    out_d   = out_q;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          crc_d   = crc_stepped;
          out_d   = crc_in;
          count_d = (DATA_LEN == 1) ? '0 : CNT_ONE;
          state_d = (DATA_LEN == 1) ? CRC : DATA;
        end else begin
          crc_d   = INIT;
          out_d   = 1'b0;
          count_d = '0;
        end
      end

      // enable low here is a pause: count, CRC register and output all hold.
      DATA: begin
        if (enable) begin
          crc_d = crc_stepped;
          out_d = crc_in;
          if (count_q == LAST_DATA) begin
            count_d = '0;
            state_d = CRC;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
      end

      // CRC_W shift edges, then one closing edge that zeroes the line and reloads INIT.
      CRC: begin
        if (count_q == CRC_END) begin
          state_d = IDLE;
          count_d = '0;
          crc_d   = INIT;
          out_d   = 1'b0;
        end else begin
          out_d   = crc_q[CRC_W-1];
          crc_d   = {crc_q[CRC_W-2:0], 1'b0};
          count_d = count_q + CNT_ONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rstn) begin
      state_q <= IDLE;
      count_q <= '0;
      crc_q   <= INIT;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      crc_q   <= crc_d;
      out_q   <= out_d;
    end
  end

  assign crc_out = out_q;

endmodule

// File: tb/tb_crc_transmitter.sv
// Directed bench for crc_transmitter with default CRC-8 parameters.
// Inputs change 1 time unit after each rising edge; crc_out is sampled there too.
module tb_crc_transmitter;

  logic clk = 1'b0;
  logic rstn;
  logic enable;
  logic crc_in;
  logic crc_out;

  int total = 0;
  int bad   = 0;

  crc_transmitter dut (
    .clk     (clk),
    .rstn    (rstn),
    .enable  (enable),
    .crc_in  (crc_in),
    .crc_out (crc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one payload MSB-first; optionally pause 3 cycles after bit index pause_after.
  task automatic send_payload(input string tag, input logic [7:0] p, input int pause_after);
    for (int i = 0; i < 8; i++) begin
      enable = 1'b1;
      crc_in = p[7-i];
      tick();
      check($sformatf("%s_d%0d", tag, i), 32'(crc_out), 32'(p[7-i]));
      if (i == pause_after) begin
        for (int k = 0; k < 3; k++) begin
          enable = 1'b0;
          crc_in = ~p[7-i];
          tick();
          check($sformatf("%s_pause%0d", tag, k), 32'(crc_out), 32'(p[7-i]));
        end
      end
    end
  endtask

  // Check the first n CRC bits; enable toggles and crc_in is held high to show both are ignored.
  task automatic send_crc(input string tag, input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      enable = i[0];
      crc_in = 1'b1;
      tick();
      check($sformatf("%s_c%0d", tag, i), 32'(crc_out), 32'(c[7-i]));
    end
  endtask

  task automatic closing_bit(input string tag, input logic en);
    enable = en;
    crc_in = 1'b1;
    tick();
    check($sformatf("%s_tail", tag), 32'(crc_out), 32'(0));
  endtask

  initial begin
    rstn   = 1'b0;
    enable = 1'b1;
    crc_in = 1'b1;
    tick();
    check("rst0", 32'(crc_out), 32'(0));
    tick();
    check("rst1", 32'(crc_out), 32'(0));

    // First post-reset edge samples bit 0, so a leading 1 shows up right after it.
    rstn = 1'b1;
    send_payload("f80", 8'h80, -1);
    send_crc("f80", 8'h89, 8);
    closing_bit("f80", 1'b0);

    enable = 1'b0;
    crc_in = 1'b1;
    tick();
    check("idle0", 32'(crc_out), 32'(0));
    tick();
    check("idle1", 32'(crc_out), 32'(0));

    send_payload("f01", 8'h01, -1);
    send_crc("f01", 8'h07, 8);
    closing_bit("f01", 1'b0);

    send_payload("f00", 8'h00, -1);
    send_crc("f00", 8'h00, 8);
    closing_bit("f00", 1'b0);

    send_payload("p80", 8'h80, 3);
    send_crc("p80", 8'h89, 8);
    closing_bit("p80", 1'b0);

    // Abort during the CRC phase; the next frame must start from INIT.
    send_payload("a80", 8'h80, -1);
    send_crc("a80", 8'h89, 4);
    rstn   = 1'b0;
    enable = 1'b1;
    crc_in = 1'b1;
    tick();
    check("abort_rst", 32'(crc_out), 32'(0));
    rstn   = 1'b1;
    enable = 1'b0;
    tick();
    check("abort_idle", 32'(crc_out), 32'(0));
    send_payload("r01", 8'h01, -1);
    send_crc("r01", 8'h07, 8);
    closing_bit("r01", 1'b0);

    // Back-to-back with enable high: exactly one zero bit between frames.
    send_payload("b01", 8'h01, -1);
    send_crc("b01", 8'h07, 8);
    closing_bit("b01", 1'b1);
    send_payload("b80", 8'h80, -1);
    send_crc("b80", 8'h89, 8);
    closing_bit("b80", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
